// File: rtl/div_sequencer_pkg.sv
// Shared types for the M-extension divide sequencer.
package div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor magnitude, and record the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           ge;

    assign shifted = {rem[WIDTH-1:0], q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dmag};
    // The top bit of a settled partial remainder is always zero; folding it in
    // keeps the compare well defined even if that ever stops holding.
    assign ge      = rem[WIDTH] | (shifted >= {1'b0, dmag});

    always_comb begin
        rem_next = shifted;
        q_next   = {q[WIDTH-2:0], 1'b0};
        if (ge) begin
            rem_next = diff;
            q_next   = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller: sign handling, RISC-V special
// cases, and a WIDTH-step restoring divide with a one-cycle result pulse.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             div_sign,
    input  logic             want_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dmag_q;
    logic             sign_q;
    logic             want_rem_q;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .q        (quo_q),
        .dmag     (dmag_q),
        .rem_next (rem_nx),
        .q_next   (quo_nx)
    );

    // Operand conditioning and special-case detection for the launch cycle
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] spec_res;

    assign a_neg    = div_sign & dividend[WIDTH-1];
    assign b_neg    = div_sign & divisor[WIDTH-1];
    assign a_mag    = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag    = b_neg ? (~divisor + 1'b1) : divisor;
    assign div_zero = (divisor == '0);
    assign ovf      = div_sign & (dividend == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor);
    assign spec_res = div_zero ? (want_rem ? dividend : '1)
                               : (want_rem ? '0 : dividend);

    // Sign fix on the final iteration's outputs, registered on entry to DONE
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;
    logic [WIDTH-1:0] fin_res;

    assign fin_q   = (sign_q & neg_q) ? (~quo_nx + 1'b1) : quo_nx;
    assign fin_r   = (sign_q & neg_r) ? (~rem_nx[WIDTH-1:0] + 1'b1) : rem_nx[WIDTH-1:0];
    assign fin_res = want_rem_q ? fin_r : fin_q;

    assign stall = start & ~flush & ~result_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dmag_q       <= '0;
            sign_q       <= 1'b0;
            want_rem_q   <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            result_valid <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            sign_q     <= div_sign;
                            want_rem_q <= want_rem;
                            neg_q      <= a_neg ^ b_neg;
                            neg_r      <= a_neg;
                            quo_q      <= a_mag;
                            dmag_q     <= b_mag;
                            rem_q      <= '0;
                            cnt        <= CNT_W'(WIDTH - 1);
                            busy       <= 1'b1;
                            if (div_zero | ovf) begin
                                state        <= DONE;
                                result       <= spec_res;
                                result_valid <= 1'b1;
                            end else begin
                                state <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state        <= DONE;
                            result       <= fin_res;
                            result_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
